mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: width of fetch_pc_in, ls_addr_in and mem_a.
REQ-002 The module SHALL have one clock; reset is synchronous and active-high: clk  in  1  rising-edge clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 flush_in  in  1  exception flush from reorder buffer.
REQ-005 fetch_req_in  in  1  fetcher requests 4-byte instruction read; held until fetch_done_out.
REQ-006 fetch_pc_in  in  ADDR_W  instruction address.
REQ-007 fetch_done_out  out  1  one-cycle pulse, instr_out valid.
REQ-008 instr_out  out  32  fetched instruction, little-endian.
REQ-009 ls_req_in  in  1  load/store buffer request; held until ls_done_out.
REQ-010 ls_wr_in  in  1  1=store, 0=load.
REQ-011 ls_size_in  in  2  0=1 byte, 1=2 bytes, 2=4 bytes; 3 treated as 4 bytes.
REQ-012 ls_addr_in  in  ADDR_W  byte address, no alignment required.
REQ-013 ls_wdata_in  in  32  store data, low bytes used.
REQ-014 ls_done_out  out  1  one-cycle completion pulse, load or store.
REQ-015 ls_rdata_out  out  32  load data, zero-extended.
REQ-016 mem_din  in  8  RAM read byte, valid one cycle after its address.
REQ-017 mem_dout  out  8  RAM write byte.
REQ-018 mem_a  out  ADDR_W  RAM byte address.
REQ-019 mem_wr  out  1  RAM write strobe.

Function
REQ-020 States SHALL be IDLE, FETCH, LOAD, STORE; all outputs registered.
REQ-021 In IDLE, at an edge where a request is high and neither done output is high, the block SHALL grant, latch address/size/data, enter the matching state and drive byte 0 address.
REQ-022 Transfers SHALL be serial byte by byte, little-endian: byte i uses address base+i (ADDR_W wrap-around) and bits [8i+7:8i].
REQ-023 Reads: mem_a=base+i in transfer cycle i, mem_din captured at end of cycle i+1; done pulse in cycle N+1, N=byte count (4-byte fetch: done visible after the 6th edge counting the grant edge).
REQ-024 Stores: mem_wr=1 with mem_a/mem_dout for byte i in cycle i, i=0..N-1; mem_wr=0 thereafter; ls_done_out in cycle N.
REQ-025 On completion the state SHALL return to IDLE on the same edge done asserts; no grant at that edge or the next (done-high cycle).
REQ-026 Arbitration with both requests high in IDLE: load/store SHALL win.
REQ-027 flush_in high at an edge in FETCH or LOAD SHALL force IDLE, mem_wr=0, no done pulse; instr_out/ls_rdata_out keep prior values.
REQ-028 flush_in in STORE SHALL be ignored; store completes and pulses ls_done_out.
REQ-029 flush_in high in IDLE SHALL suppress grant at that edge.
REQ-030 mem_wr SHALL be 0 outside STORE; mem_a holds last value when IDLE.

Reset
REQ-031 rst high at an edge SHALL, overriding flush and any transfer (including mid-store), set state IDLE, byte counter 0, all outputs 0, last-grant register to LS.

Configuration
REQ-032 Macro MEMARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant goes to the requester not granted most recently (last-grant register, reset LS, so fetch wins first); undefined: fixed LS priority per REQ-026, last-grant register absent.

Verification
REQ-033 Fetch 0x00001000, RAM 13 05 00 00 -> mem_a 0x1000..0x1003, instr_out=0x00000513, fetch_done_out one cycle after 6th edge.
REQ-034 Store word 0xDEADBEEF at 0x20 -> mem_wr 4 cycles writing EF,BE,AD,DE to 0x20..0x23, ls_done_out then, single pulse.
REQ-035 Load halfword at 0x31, RAM 80 FF -> ls_rdata_out=0x0000FF80, 2-byte sequence, no mem_wr.
REQ-036 Fetch and load requested same edge -> load first then fetch; with MEMARB_ROUND_ROBIN_EN after reset, fetch first, then load, repeating alternation.
REQ-037 flush_in during fetch byte 2 -> IDLE next edge, no fetch_done_out; flush_in during store byte 1 -> all 4 bytes written, ls_done_out pulses.
REQ-038 rst during load byte 1 -> next cycle all outputs 0, state IDLE, no done pulse; new request then granted normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter and its clients: instruction fetcher,
// load/store buffer and a byte-wide synchronous RAM.
// slave  : arbiter side (consumes requests and RAM read data).
// master : environment side (fetcher, load/store buffer, RAM).
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32
) ();

  logic              flush_in;
  logic              fetch_req_in;
  logic [ADDR_W-1:0] fetch_pc_in;
  logic              fetch_done_out;
  logic [31:0]       instr_out;
  logic              ls_req_in;
  logic              ls_wr_in;
  logic [1:0]        ls_size_in;
  logic [ADDR_W-1:0] ls_addr_in;
  logic [31:0]       ls_wdata_in;
  logic              ls_done_out;
  logic [31:0]       ls_rdata_out;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;

  modport slave (
    input  flush_in, fetch_req_in, fetch_pc_in, ls_req_in, ls_wr_in, ls_size_in,
           ls_addr_in, ls_wdata_in, mem_din,
    output fetch_done_out, instr_out, ls_done_out, ls_rdata_out, mem_dout, mem_a, mem_wr
  );

  modport master (
    output flush_in, fetch_req_in, fetch_pc_in, ls_req_in, ls_wr_in, ls_size_in,
           ls_addr_in, ls_wdata_in, mem_din,
    input  fetch_done_out, instr_out, ls_done_out, ls_rdata_out, mem_dout, mem_a, mem_wr
  );

endinterface

// File: rtl/mem_arbiter.sv
// Memory arbiter: serialises 4-byte instruction fetches and 1/2/4-byte loads
// and stores onto a byte-wide RAM (one-cycle read latency), little-endian.
// Optional build macro MEMARB_ROUND_ROBIN_EN: alternate grants between the
// fetcher and the load/store buffer on simultaneous requests; otherwise the
// load/store buffer always wins.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus_io
);

  typedef enum logic [1:0] {StIdle, StFetch, StLoad, StStore} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        len_q, len_d;
  logic [2:0]        cnt_nxt;
  logic [1:0]        cap_idx;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       buf_q, buf_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;
  logic              fetch_done_q, fetch_done_d;
  logic              ls_done_q, ls_done_d;
  logic              grant_ok;
  logic              pick_ls;
`ifdef MEMARB_ROUND_ROBIN_EN
  logic              last_ls_q, last_ls_d;
`endif

  function automatic logic [2:0] size_to_len(input logic [1:0] size);
    case (size)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  assign cnt_nxt = cnt_q + 3'd1;
  // cnt_q counts transfer cycles; the byte arriving now was addressed one cycle earlier.
  assign cap_idx = cnt_q[1:0] - 2'd1;

  // Grant qualification and winner selection for IDLE.
  always_comb begin
    grant_ok = !bus_io.flush_in && !fetch_done_q && !ls_done_q &&
               (bus_io.fetch_req_in || bus_io.ls_req_in);
`ifdef MEMARB_ROUND_ROBIN_EN
    pick_ls  = bus_io.ls_req_in && (!bus_io.fetch_req_in || !last_ls_q);
`else
    pick_ls  = bus_io.ls_req_in;
`endif
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    base_d       = base_q;
    wdata_d      = wdata_q;
    buf_d        = buf_q;
    instr_d      = instr_q;
    rdata_d      = rdata_q;
    mem_a_d      = mem_a_q;
    mem_dout_d   = mem_dout_q;
    mem_wr_d     = mem_wr_q;
    fetch_done_d = 1'b0;
    ls_done_d    = 1'b0;
`ifdef MEMARB_ROUND_ROBIN_EN
    last_ls_d    = last_ls_q;
`endif
    unique case (state_q)
      StIdle: begin
        mem_wr_d = 1'b0;
        if (grant_ok) begin
          cnt_d = 3'd0;
          buf_d = 32'd0;
          if (pick_ls) begin
            base_d  = bus_io.ls_addr_in;
            mem_a_d = bus_io.ls_addr_in;
            len_d   = size_to_len(bus_io.ls_size_in);
            wdata_d = bus_io.ls_wdata_in;
            if (bus_io.ls_wr_in) begin
              state_d    = StStore;
              mem_wr_d   = 1'b1;
              mem_dout_d = bus_io.ls_wdata_in[7:0];
            end else begin
              state_d = StLoad;
            end
`ifdef MEMARB_ROUND_ROBIN_EN
            last_ls_d = 1'b1;
`endif
          end else begin
            base_d  = bus_io.fetch_pc_in;
            mem_a_d = bus_io.fetch_pc_in;
            len_d   = 3'd4;
            state_d = StFetch;
`ifdef MEMARB_ROUND_ROBIN_EN
            last_ls_d = 1'b0;
`endif
          end
        end
      end
      StFetch, StLoad: begin
        if (bus_io.flush_in) begin
          // Abandon the read; result registers keep their previous values.
          state_d = StIdle;
        end else begin
          if (cnt_q != 3'd0) begin
            buf_d = buf_q | ({24'd0, bus_io.mem_din} << {cap_idx, 3'b000});
          end
          if (cnt_nxt < len_q) begin
            mem_a_d = base_q + ADDR_W'(cnt_nxt);
          end
          if (cnt_q == len_q) begin
            state_d = StIdle;
            if (state_q == StFetch) begin
              fetch_done_d = 1'b1;
              instr_d      = buf_d;
            end else begin
              ls_done_d = 1'b1;
              rdata_d   = buf_d;
            end
          end
          cnt_d = cnt_nxt;
        end
      end
      StStore: begin
        // Flush is deliberately ignored: a store already on the bus must finish.
        if (cnt_nxt == len_q) begin
          mem_wr_d  = 1'b0;
          ls_done_d = 1'b1;
          state_d   = StIdle;
        end else begin
          mem_a_d    = base_q + ADDR_W'(cnt_nxt);
          mem_dout_d = wdata_q[{cnt_nxt[1:0], 3'b000} +: 8];
        end
        cnt_d = cnt_nxt;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 3'd0;
      len_q        <= 3'd0;
      base_q       <= '0;
      wdata_q      <= 32'd0;
      buf_q        <= 32'd0;
      instr_q      <= 32'd0;
      rdata_q      <= 32'd0;
      mem_a_q      <= '0;
      mem_dout_q   <= 8'd0;
      mem_wr_q     <= 1'b0;
      fetch_done_q <= 1'b0;
      ls_done_q    <= 1'b0;
`ifdef MEMARB_ROUND_ROBIN_EN
      last_ls_q    <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      base_q       <= base_d;
      wdata_q      <= wdata_d;
      buf_q        <= buf_d;
      instr_q      <= instr_d;
      rdata_q      <= rdata_d;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
      mem_wr_q     <= mem_wr_d;
      fetch_done_q <= fetch_done_d;
      ls_done_q    <= ls_done_d;
`ifdef MEMARB_ROUND_ROBIN_EN
      last_ls_q    <= last_ls_d;
`endif
    end
  end

  assign bus_io.fetch_done_out = fetch_done_q;
  assign bus_io.instr_out      = instr_q;
  assign bus_io.ls_done_out    = ls_done_q;
  assign bus_io.ls_rdata_out   = rdata_q;
  assign bus_io.mem_dout       = mem_dout_q;
  assign bus_io.mem_a          = mem_a_q;
  assign bus_io.mem_wr         = mem_wr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cases plus random transfers
// against a byte-array RAM and a transaction-level expectation model.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW)) bus ();

  mem_arbiter #(.ADDR_W(AW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  // Byte RAM, indexed by the low address byte; read data appears one cycle later.
  logic [7:0] ram [256];
  always @(posedge clk) begin
    bus.mem_din <= ram[bus.mem_a[7:0]];
    if (bus.mem_wr) ram[bus.mem_a[7:0]] <= bus.mem_dout;
  end

  int tests = 0;
  int fails = 0;
  bit last_ls_m;  // model of who was granted most recently (1 = load/store)

  int          r_kind, r_fa;
  logic [31:0] r_addr, r_wd, prev_v;
  logic [1:0]  r_size;
  bit          r_ff, seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ram_word(input logic [31:0] addr, input int n);
    logic [31:0] v, a;
    v = 32'd0;
    for (int i = 0; i < n; i++) begin
      a = addr + i;
      v = v | (32'(ram[a[7:0]]) << (8 * i));
    end
    return v;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_fdone"}, 32'(bus.fetch_done_out), 32'd0);
    chk({tag, "_instr"}, bus.instr_out, 32'd0);
    chk({tag, "_lsdone"}, 32'(bus.ls_done_out), 32'd0);
    chk({tag, "_rdata"}, bus.ls_rdata_out, 32'd0);
    chk({tag, "_dout"}, 32'(bus.mem_dout), 32'd0);
    chk({tag, "_mema"}, bus.mem_a, 32'd0);
    chk({tag, "_memwr"}, 32'(bus.mem_wr), 32'd0);
  endtask

  // kind: 0 fetch, 1 load, 2 store. flush_first holds flush_in over the first
  // edge (grant must wait one edge). flush_at asserts flush after that sample.
  task automatic txn(input int kind, input logic [31:0] addr, input logic [1:0] size,
                     input logic [31:0] wd, input bit flush_first, input int flush_at);
    int          n, lat, k, off, idx;
    bit          done, other;
    logic [31:0] exp_data, prev_instr, prev_rdata, tmp;
    logic [31:0] a_s [32];
    logic        wr_s [32];
    logic [7:0]  d_s [32];
    n          = (kind == 0) ? 4 : nbytes(size);
    off        = flush_first ? 1 : 0;
    lat        = ((kind == 2) ? n + 1 : n + 2) + off;
    exp_data   = ram_word(addr, n);
    prev_instr = bus.instr_out;
    prev_rdata = bus.ls_rdata_out;
    if (kind == 0) begin
      bus.fetch_pc_in  = addr;
      bus.fetch_req_in = 1'b1;
    end else begin
      bus.ls_addr_in  = addr;
      bus.ls_size_in  = size;
      bus.ls_wr_in    = (kind == 2);
      bus.ls_wdata_in = wd;
      bus.ls_req_in   = 1'b1;
    end
    bus.flush_in = flush_first;
    k = 0; done = 1'b0; other = 1'b0;
    while (!done && k < 30) begin
      @(posedge clk); #1;
      k++;
      bus.flush_in = (k == flush_at);
      a_s[k]  = bus.mem_a;
      wr_s[k] = bus.mem_wr;
      d_s[k]  = bus.mem_dout;
      done    = (kind == 0) ? bus.fetch_done_out : bus.ls_done_out;
      if ((kind == 0) ? bus.ls_done_out : bus.fetch_done_out) other = 1'b1;
    end
    bus.flush_in = 1'b0; bus.fetch_req_in = 1'b0; bus.ls_req_in = 1'b0;
    chk("latency", k, lat);
    for (int i = 0; i < n; i++) begin
      idx = off + i + 1;
      chk("byte_addr", a_s[idx], addr + i);
      if (kind == 2) begin
        tmp = wd >> (8 * i);
        chk("store_wr", 32'(wr_s[idx]), 32'd1);
        chk("store_dout", 32'(d_s[idx]), 32'(tmp[7:0]));
      end else begin
        chk("read_no_wr", 32'(wr_s[idx]), 32'd0);
      end
    end
    chk("done_mema_hold", a_s[k], addr + n - 1);
    chk("done_memwr", 32'(wr_s[k]), 32'd0);
    chk("other_done", 32'(other), 32'd0);
    if (kind == 0) begin
      chk("instr", bus.instr_out, exp_data);
      chk("rdata_kept", bus.ls_rdata_out, prev_rdata);
    end else if (kind == 1) begin
      chk("rdata", bus.ls_rdata_out, exp_data);
      chk("instr_kept", bus.instr_out, prev_instr);
    end else begin
      for (int i = 0; i < n; i++) begin
        tmp = addr + i;
        idx = int'(tmp[7:0]);
        tmp = wd >> (8 * i);
        chk("ram_written", 32'(ram[idx]), 32'(tmp[7:0]));
      end
      chk("instr_kept", bus.instr_out, prev_instr);
      chk("rdata_kept", bus.ls_rdata_out, prev_rdata);
    end
    last_ls_m = (kind != 0);
    @(posedge clk); #1;
    chk("single_pulse", 32'((kind == 0) ? bus.fetch_done_out : bus.ls_done_out), 32'd0);
  endtask

  // Fetch and 4-byte load raised together; checks service order and timing.
  task automatic arb(input logic [31:0] pc, input logic [31:0] la);
    int          first, exp_first, k;
    bit          fd, ld;
    logic [31:0] e_instr, e_rdata;
    e_instr = ram_word(pc, 4);
    e_rdata = ram_word(la, 4);
`ifdef MEMARB_ROUND_ROBIN_EN
    exp_first = last_ls_m ? 1 : 2;
`else
    exp_first = 2;
`endif
    bus.fetch_pc_in = pc; bus.fetch_req_in = 1'b1;
    bus.ls_addr_in = la; bus.ls_size_in = 2'd2; bus.ls_wr_in = 1'b0; bus.ls_req_in = 1'b1;
    first = 0; fd = 1'b0; ld = 1'b0; k = 0;
    while (!(fd && ld) && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (bus.fetch_done_out && !fd) begin
        fd = 1'b1; bus.fetch_req_in = 1'b0;
        if (first == 0) first = 1;
      end
      if (bus.ls_done_out && !ld) begin
        ld = 1'b1; bus.ls_req_in = 1'b0;
        if (first == 0) first = 2;
      end
    end
    bus.fetch_req_in = 1'b0; bus.ls_req_in = 1'b0;
    chk("arb_first", first, exp_first);
    chk("arb_both_done", {30'd0, fd, ld}, 32'd3);
    // Second grant waits out the done-high cycle: 6 + 1 idle + 6 samples.
    chk("arb_total_cycles", k, 13);
    chk("arb_instr", bus.instr_out, e_instr);
    chk("arb_rdata", bus.ls_rdata_out, e_rdata);
    last_ls_m = (first == 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.flush_in = 1'b0; bus.fetch_req_in = 1'b0; bus.fetch_pc_in = '0;
    bus.ls_req_in = 1'b0; bus.ls_wr_in = 1'b0; bus.ls_size_in = 2'd0;
    bus.ls_addr_in = '0; bus.ls_wdata_in = 32'd0;
    for (int i = 0; i < 256; i++) ram[i] <= 8'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    last_ls_m = 1'b1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Fetch of 0x00001000 returning 13 05 00 00.
    ram[8'h00] <= 8'h13; ram[8'h01] <= 8'h05; ram[8'h02] <= 8'h00; ram[8'h03] <= 8'h00;
    #1;
    txn(0, 32'h0000_1000, 2'd2, 32'd0, 1'b0, 0);
    chk("fetch_1000_instr", bus.instr_out, 32'h0000_0513);

    // Word store of 0xDEADBEEF at 0x20.
    txn(2, 32'h0000_0020, 2'd2, 32'hDEAD_BEEF, 1'b0, 0);
    chk("store_20_b0", 32'(ram[8'h20]), 32'h0000_00EF);
    chk("store_20_b3", 32'(ram[8'h23]), 32'h0000_00DE);

    // Unaligned halfword load at 0x31 of 80 FF.
    ram[8'h31] <= 8'h80; ram[8'h32] <= 8'hFF;
    #1;
    txn(1, 32'h0000_0031, 2'd1, 32'd0, 1'b0, 0);
    chk("load_31_rdata", bus.ls_rdata_out, 32'h0000_FF80);

    txn(1, 32'h0000_0055, 2'd0, 32'd0, 1'b0, 0);        // byte load, zero-extended
    txn(1, 32'h0000_0060, 2'd3, 32'd0, 1'b0, 0);        // size 3 behaves as word
    txn(0, 32'hFFFF_FFFE, 2'd2, 32'd0, 1'b0, 0);        // address wrap-around
    txn(2, 32'h0000_0080, 2'd2, 32'h1122_3344, 1'b0, 2); // flush during store byte 1
    txn(1, 32'h0000_0010, 2'd2, 32'd0, 1'b1, 0);        // flush in IDLE delays grant

    // Flush during fetch byte 2: no done, instr_out unchanged, mem_a held.
    prev_v = bus.instr_out;
    bus.fetch_pc_in = 32'h0000_2000; bus.fetch_req_in = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("flushf_byte2_addr", bus.mem_a, 32'h0000_2002);
    bus.flush_in = 1'b1; bus.fetch_req_in = 1'b0;
    @(posedge clk); #1;
    bus.flush_in = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      if (bus.fetch_done_out) seen = 1'b1;
      @(posedge clk); #1;
    end
    if (bus.fetch_done_out) seen = 1'b1;
    chk("flushf_no_done", 32'(seen), 32'd0);
    chk("flushf_instr_kept", bus.instr_out, prev_v);
    chk("flushf_memwr", 32'(bus.mem_wr), 32'd0);
    chk("flushf_mema_held", bus.mem_a, 32'h0000_2002);
    last_ls_m = 1'b0;
    txn(0, 32'h0000_2000, 2'd2, 32'd0, 1'b0, 0);

    // Reset during load byte 1.
    bus.ls_addr_in = 32'h0000_0040; bus.ls_size_in = 2'd2; bus.ls_wr_in = 1'b0;
    bus.ls_req_in = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("rstld_byte1_addr", bus.mem_a, 32'h0000_0041);
    rst = 1'b1; bus.ls_req_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check_all_zero("rst_mid_load");
    last_ls_m = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.ls_done_out || bus.fetch_done_out) seen = 1'b1;
    end
    chk("rstld_no_done", 32'(seen), 32'd0);
    txn(1, 32'h0000_0040, 2'd2, 32'd0, 1'b0, 0);

    // Arbitration from a fresh reset, twice in a row.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    last_ls_m = 1'b1;
    arb(32'h0000_3000, 32'h0000_0090);
    arb(32'h0000_3100, 32'h0000_00A0);

    // Random transfers.
    for (int t = 0; t < 40; t++) begin
      r_kind = int'($urandom_range(0, 2));
      r_addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3) : $urandom;
      r_size = 2'($urandom_range(0, 3));
      r_wd   = $urandom;
      r_ff   = ($urandom_range(0, 7) == 0);
      r_fa   = (r_kind == 2 && !r_ff && $urandom_range(0, 1) == 1) ?
               int'($urandom_range(1, nbytes(r_size))) : 0;
      txn(r_kind, r_addr, r_size, r_wd, r_ff, r_fa);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
